// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_fifo : single-clock UART transmitter with transmit FIFO      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 2,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        pclk_i,
  input  logic                        prst_n_i,
  input  logic [DATA_BITS-1:0]        tx_pdata_i,
  input  logic                        tx_pdata_valid_i,
  output logic                        tx_pready_o,
  input  logic                        tx_en_i,
  output logic                        tx_sdata_o,
  output logic                        tx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0] tx_fifo_count_o
);

  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam int c_baud_w = $clog2(CLKS_PER_BIT);
  localparam int c_idx_w  = $clog2(DATA_BITS);

  localparam logic [c_cnt_w-1:0]  c_full       = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_baud_w-1:0] c_baud_last  = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0]  c_data_last  = c_idx_w'(DATA_BITS - 1);
  localparam logic [c_idx_w-1:0]  c_stop_last  = c_idx_w'(STOP_BITS - 1);
  localparam bit                  c_has_parity = (PARITY_MODE != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  state_t               r_state;
  logic [c_baud_w-1:0]  r_baud;
  logic [c_idx_w-1:0]   r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_sdata;
  logic                 r_busy;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_parity;

  assign tx_pready_o     = (r_count != c_full);
  assign tx_fifo_count_o = r_count;
  assign tx_sdata_o      = r_sdata;
  assign tx_busy_o       = r_busy;

  assign w_head        = r_mem[r_rd_ptr];
  assign w_head_parity = (PARITY_MODE == 1) ? ^w_head : ~^w_head;
  assign w_push        = tx_pdata_valid_i && tx_pready_o;
  assign w_bit_end     = (r_baud == c_baud_last);
  assign w_frame_end   = (r_state == S_STOP) && w_bit_end && (r_bit_idx == c_stop_last);
  // The last stop cycle may chain straight into the next start bit.
  assign w_pop         = tx_en_i && (r_count != '0) &&
                         ((r_state == S_IDLE) || w_frame_end);

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_pdata_i;
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_sdata   <= 1'b1;
      r_busy    <= 1'b0;
    end else if (w_pop) begin
      r_state   <= S_START;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= w_head;
      r_parity  <= w_head_parity;
      r_sdata   <= 1'b0;
      r_busy    <= 1'b1;
    end else if (r_state != S_IDLE) begin
      if (!w_bit_end) begin
        r_baud <= r_baud + 1'b1;
      end else begin
        r_baud <= '0;
        case (r_state)
          S_START: begin
            r_state <= S_DATA;
            r_sdata <= r_shift[0];
          end
          S_DATA: begin
            if (r_bit_idx == c_data_last) begin
              r_bit_idx <= '0;
              if (c_has_parity) begin
                r_state <= S_PARITY;
                r_sdata <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_sdata <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_sdata   <= r_shift[1];
            end
          end
          S_PARITY: begin
            r_state <= S_STOP;
            r_sdata <= 1'b1;
          end
          S_STOP: begin
            if (r_bit_idx == c_stop_last) begin
              r_state   <= S_IDLE;
              r_bit_idx <= '0;
              r_busy    <= 1'b0;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_sdata <= 1'b1;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_fifo : scoreboard bench for uart_tx_fifo                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_tx_fifo;

  logic       pclk    = 1'b0;
  logic       prst_n  = 1'b0;
  logic [7:0] pdata   = 8'h00;
  logic       en      = 1'b0;
  logic       valid_m = 1'b0;
  logic       valid_e = 1'b0;
  logic       valid_7 = 1'b0;

  logic       ready_m, sdata_m, busy_m;
  logic       ready_e, sdata_e, busy_e;
  logic       ready_7, sdata_7, busy_7;
  logic [2:0] count_m, count_e, count_7;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  int         sel      = 0;
  bit         mon_on   = 1'b0;
  logic [7:0] sb[$];
  int         starts[$];
  logic       cap_line;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  always_comb begin
    cap_line = sdata_m;
    if (sel == 1)      cap_line = sdata_e;
    else if (sel == 2) cap_line = sdata_7;
  end

  uart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_odd (
    .pclk_i(pclk), .prst_n_i(prst_n), .tx_pdata_i(pdata), .tx_pdata_valid_i(valid_m),
    .tx_pready_o(ready_m), .tx_en_i(en), .tx_sdata_o(sdata_m), .tx_busy_o(busy_m),
    .tx_fifo_count_o(count_m));

  uart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_even (
    .pclk_i(pclk), .prst_n_i(prst_n), .tx_pdata_i(pdata), .tx_pdata_valid_i(valid_e),
    .tx_pready_o(ready_e), .tx_en_i(en), .tx_sdata_o(sdata_e), .tx_busy_o(busy_e),
    .tx_fifo_count_o(count_e));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_7n2 (
    .pclk_i(pclk), .prst_n_i(prst_n), .tx_pdata_i(pdata[6:0]), .tx_pdata_valid_i(valid_7),
    .tx_pready_o(ready_7), .tx_en_i(en), .tx_sdata_o(sdata_7), .tx_busy_o(busy_7),
    .tx_fifo_count_o(count_7));

  // Reference frame for the odd-parity instance: start, 8 data LSB first, parity, stop.
  function automatic logic [43:0] expected_wave(input logic [7:0] d);
    logic [10:0] bits;
    logic [43:0] w;
    bits = {1'b1, ~^d, d, 1'b0};
    for (int i = 0; i < 44; i++) w[i] = bits[i/4];
    return w;
  endfunction

  function automatic logic [63:0] expand(input logic [15:0] bits, input int nbits);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < nbits*4; i++) w[i] = bits[i/4];
    return w;
  endfunction

  initial begin : monitor
    logic [43:0] wave;
    logic [7:0]  exp_d;
    bit          aborted;
    forever begin
      @(posedge pclk); #1;
      if (mon_on && sdata_m === 1'b0) begin
        starts.push_back(cyc);
        wave    = '0;
        aborted = 1'b0;
        for (int i = 1; i < 44; i++) begin
          @(posedge pclk); #1;
          if (!mon_on) begin
            aborted = 1'b1;
            break;
          end
          wave[i] = sdata_m;
        end
        if (!aborted) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL frame_unexpected: got line %b, required no frame", wave);
          end else begin
            exp_d = sb.pop_front();
            if (wave !== expected_wave(exp_d)) begin
              n_errors++;
              $display("FAIL frame_%h: got line %b, required %b", exp_d, wave, expected_wave(exp_d));
            end
          end
        end
      end
    end
  end

  task automatic push_m(input logic [7:0] d);
    pdata   = d;
    valid_m = 1'b1;
    @(posedge pclk); #1;
    valid_m = 1'b0;
    sb.push_back(d);
  endtask

  task automatic wait_main_idle(input int max_c, output int waited);
    waited = 0;
    while (busy_m === 1'b1 && waited < max_c) begin
      @(posedge pclk); #1;
      waited++;
    end
  endtask

  task automatic capture(input int nbits, output logic [63:0] got);
    int t;
    got = '0;
    t   = 0;
    while (cap_line !== 1'b0 && t < 20) begin
      @(posedge pclk); #1;
      t++;
    end
    if (cap_line !== 1'b0) begin
      got = '1;
    end else begin
      for (int i = 1; i < nbits*4; i++) begin
        @(posedge pclk); #1;
        got[i] = cap_line;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge pclk);
    #1;
    n_checks++; if (sdata_m !== 1'b1) begin n_errors++; $display("FAIL reset_sdata: got %b, required 1", sdata_m); end
    n_checks++; if (busy_m !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, required 0", busy_m); end
    n_checks++; if (count_m !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d, required 0", count_m); end
    n_checks++; if (ready_m !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b, required 1", ready_m); end
    prst_n = 1'b1;
    @(posedge pclk); #1;
    n_checks++; if (sdata_m !== 1'b1) begin n_errors++; $display("FAIL post_reset_idle: got %b, required 1", sdata_m); end
  endtask

  task automatic test_single_frame();
    int busy_cnt;
    en     = 1'b1;
    mon_on = 1'b1;
    pdata  = 8'hA5;
    valid_m = 1'b1;
    @(posedge pclk); #1;
    valid_m = 1'b0;
    sb.push_back(8'hA5);
    pdata = 8'hFF;
    n_checks++; if (count_m !== 3'd1 || sdata_m !== 1'b1) begin n_errors++; $display("FAIL push_edge: got count %0d line %b, required count 1 line 1", count_m, sdata_m); end
    @(posedge pclk); #1;
    n_checks++; if (sdata_m !== 1'b0 || busy_m !== 1'b1) begin n_errors++; $display("FAIL start_latency: got line %b busy %b, required line 0 busy 1", sdata_m, busy_m); end
    n_checks++; if (count_m !== 3'd0) begin n_errors++; $display("FAIL pop_count: got %0d, required 0", count_m); end
    busy_cnt = 1;
    while (busy_m === 1'b1 && busy_cnt < 100) begin
      @(posedge pclk); #1;
      if (busy_m === 1'b1) busy_cnt++;
    end
    n_checks++; if (busy_cnt != 44) begin n_errors++; $display("FAIL busy_length: got %0d cycles, required 44", busy_cnt); end
    n_checks++; if (sdata_m !== 1'b1) begin n_errors++; $display("FAIL line_idle: got %b, required 1", sdata_m); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [5];
    logic [2:0] exp_cnt;
    int         waited;
    words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h01; words[3] = 8'h80; words[4] = 8'hEE;
    en = 1'b0;
    starts.delete();
    valid_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pdata = words[i];
      @(posedge pclk); #1;
      if (i < 4) sb.push_back(words[i]);
      exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
      n_checks++;
      if (count_m !== exp_cnt || ready_m !== (exp_cnt != 3'd4)) begin
        n_errors++;
        $display("FAIL fill_%0d: got count %0d ready %b, required count %0d ready %b", i, count_m, ready_m, exp_cnt, exp_cnt != 3'd4);
      end
    end
    valid_m = 1'b0;
    en      = 1'b1;
    @(posedge pclk); #1;
    n_checks++; if (count_m !== 3'd3 || ready_m !== 1'b1 || sdata_m !== 1'b0) begin n_errors++; $display("FAIL first_pop: got count %0d ready %b line %b, required 3 1 0", count_m, ready_m, sdata_m); end
    for (int f = 1; f < 4; f++) begin
      repeat (44) @(posedge pclk);
      #1;
      n_checks++; if (count_m !== 3'(3 - f)) begin n_errors++; $display("FAIL pop_%0d_count: got %0d, required %0d", f, count_m, 3 - f); end
    end
    wait_main_idle(100, waited);
    n_checks++; if (waited >= 100) begin n_errors++; $display("FAIL b2b_idle_timeout: got busy after %0d cycles, required idle", waited); end
    n_checks++;
    if (starts.size() != 4) begin
      n_errors++; $display("FAIL b2b_frames: got %0d frame starts, required 4", starts.size());
    end else begin
      for (int f = 1; f < 4; f++)
        if (starts[f] - starts[f-1] != 44) begin
          n_errors++; $display("FAIL b2b_gap_%0d: got %0d cycles between starts, required 44", f, starts[f] - starts[f-1]);
        end
    end
  endtask

  task automatic test_en_drop();
    int waited;
    en = 1'b1;
    push_m(8'h5A);
    push_m(8'h96);
    n_checks++; if (count_m !== 3'd1 || sdata_m !== 1'b0) begin n_errors++; $display("FAIL push_pop_same_edge: got count %0d line %b, required 1 0", count_m, sdata_m); end
    repeat (10) @(posedge pclk);
    #1;
    en = 1'b0;
    wait_main_idle(60, waited);
    n_checks++; if (waited >= 60) begin n_errors++; $display("FAIL en_drop_timeout: got busy after %0d cycles, required idle", waited); end
    repeat (8) @(posedge pclk);
    #1;
    n_checks++; if (busy_m !== 1'b0 || sdata_m !== 1'b1 || count_m !== 3'd1) begin n_errors++; $display("FAIL en_halt: got busy %b line %b count %0d, required 0 1 1", busy_m, sdata_m, count_m); end
    en = 1'b1;
    @(posedge pclk); #1;
    n_checks++; if (busy_m !== 1'b1 || sdata_m !== 1'b0 || count_m !== 3'd0) begin n_errors++; $display("FAIL en_resume: got busy %b line %b count %0d, required 1 0 0", busy_m, sdata_m, count_m); end
    wait_main_idle(60, waited);
    n_checks++; if (waited >= 60) begin n_errors++; $display("FAIL resume_timeout: got busy after %0d cycles, required idle", waited); end
  endtask

  task automatic test_reset_mid_frame();
    int waited;
    en = 1'b1;
    push_m(8'h3C);
    push_m(8'hC3);
    repeat (12) @(posedge pclk);
    #1;
    mon_on = 1'b0;
    sb.delete();
    #3 prst_n = 1'b0;
    #1;
    n_checks++; if (sdata_m !== 1'b1 || busy_m !== 1'b0) begin n_errors++; $display("FAIL async_reset_line: got line %b busy %b, required 1 0", sdata_m, busy_m); end
    n_checks++; if (count_m !== 3'd0 || ready_m !== 1'b1) begin n_errors++; $display("FAIL async_reset_flush: got count %0d ready %b, required 0 1", count_m, ready_m); end
    #2 prst_n = 1'b1;
    @(posedge pclk); #1;
    mon_on = 1'b1;
    n_checks++; if (sdata_m !== 1'b1 || busy_m !== 1'b0) begin n_errors++; $display("FAIL after_release: got line %b busy %b, required 1 0", sdata_m, busy_m); end
    push_m(8'h81);
    @(posedge pclk); #1;
    wait_main_idle(60, waited);
    n_checks++; if (waited >= 60) begin n_errors++; $display("FAIL post_reset_frame_timeout: got busy after %0d cycles, required idle", waited); end
    repeat (2) @(posedge pclk);
    #1;
    n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", sb.size()); end
  endtask

  task automatic test_even_parity();
    logic [63:0] got;
    logic [63:0] exp;
    en  = 1'b1;
    sel = 1;
    pdata = 8'hA5; valid_e = 1'b1;
    @(posedge pclk); #1;
    valid_e = 1'b0;
    capture(11, got);
    exp = expand({1'b1, 1'b0, 8'hA5, 1'b0}, 11);
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL even_a5: got line %b, required %b", got[43:0], exp[43:0]); end
    n_checks++; if (got[38] !== 1'b0) begin n_errors++; $display("FAIL even_a5_parity: got %b, required 0", got[38]); end
    repeat (2) @(posedge pclk);
    #1;
    pdata = 8'h07; valid_e = 1'b1;
    @(posedge pclk); #1;
    valid_e = 1'b0;
    capture(11, got);
    exp = expand({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL even_07: got line %b, required %b", got[43:0], exp[43:0]); end
    n_checks++; if (got[38] !== 1'b1) begin n_errors++; $display("FAIL even_07_parity: got %b, required 1", got[38]); end
    @(posedge pclk); #1;
    n_checks++; if (busy_e !== 1'b0 || count_e !== 3'd0 || ready_e !== 1'b1) begin n_errors++; $display("FAIL even_idle: got busy %b count %0d ready %b, required 0 0 1", busy_e, count_e, ready_e); end
  endtask

  task automatic test_seven_bit_two_stop();
    logic [63:0] got;
    logic [63:0] exp;
    en  = 1'b1;
    sel = 2;
    pdata = 8'h41; valid_7 = 1'b1;
    @(posedge pclk); #1;
    valid_7 = 1'b0;
    pdata = 8'h00;
    capture(10, got);
    exp = expand({1'b1, 1'b1, 7'h41, 1'b0}, 10);
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL frame_7n2: got line %b, required %b", got[39:0], exp[39:0]); end
    n_checks++; if (busy_7 !== 1'b1) begin n_errors++; $display("FAIL busy_7n2_last: got %b, required 1", busy_7); end
    @(posedge pclk); #1;
    n_checks++; if (busy_7 !== 1'b0 || sdata_7 !== 1'b1) begin n_errors++; $display("FAIL end_7n2: got busy %b line %b, required 0 1", busy_7, sdata_7); end
    n_checks++; if (count_7 !== 3'd0 || ready_7 !== 1'b1) begin n_errors++; $display("FAIL fifo_7n2: got count %0d ready %b, required 0 1", count_7, ready_7); end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_en_drop();
    test_reset_mid_frame();
    test_even_parity();
    test_seven_bit_two_stop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
